// File: rtl/fact_pkg.sv
// fact_pkg: shared controller state codes, slot codes and helpers for the factorisation game
package fact_pkg;
  localparam logic [3:0] ST_QUESTION = 4'b0011;
  localparam logic [3:0] ST_INPUT    = 4'b0100;
  localparam logic [3:0] ST_DRAW     = 4'b0110;
  localparam logic [3:0] ST_GOOD     = 4'b1000;
  localparam logic [3:0] ST_OUCH     = 4'b1001;
  localparam logic [3:0] ST_WIN      = 4'b1010;
  localparam logic [3:0] ST_LOSE     = 4'b1011;
  localparam logic [3:0] IDX_NONE = 4'd0;
  localparam logic [3:0] IDX_2    = 4'd1;
  localparam logic [3:0] IDX_3    = 4'd2;
  localparam logic [3:0] IDX_5    = 4'd3;
  localparam logic [3:0] IDX_7    = 4'd4;
  typedef enum logic [1:0] {EDIT, PEND, FLUSH} ae_state_t;
  function automatic logic is_flush(input logic [3:0] s);
    return s inside {ST_DRAW, ST_GOOD, ST_OUCH, ST_WIN, ST_LOSE};
  endfunction
  function automatic logic [3:0] slot_to_prime(input logic [3:0] c);
    return c == IDX_2 ? 4'd2 : c == IDX_3 ? 4'd3 : c == IDX_5 ? 4'd5 : c == IDX_7 ? 4'd7 : 4'd0;
  endfunction
endpackage

// File: rtl/btn_edge.sv
// btn_edge: registers buttons and flags rising edges; reset to all 1s so held buttons stay silent
module btn_edge #(
  parameter int W = 1
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [W-1:0] cur,
  output logic [W-1:0] ev
);
  logic [W-1:0] prev;
  always_ff @(posedge CLK) prev <= RST ? '1 : cur;
  assign ev = cur & ~prev;
endmodule

// File: rtl/answer_entry.sv
// answer_entry: factor-slot editing, question hold and valid/ack answer commit
module answer_entry import fact_pkg::*; #(
  parameter int NSLOT   = 3,
  parameter int IDX_W   = 4,
  parameter int MAX_IDX = 4,
  parameter int Q_W     = 12,
  parameter int STATE_W = 4
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [STATE_W-1:0]     STATE,
  input  logic [NSLOT-1:0]       SEL,
  input  logic                   DIR,
  input  logic                   CLR,
  input  logic                   DEC,
  input  logic                   Q_LOAD,
  input  logic [Q_W-1:0]         Q_IN,
  output logic                   QUE_OK,
  output logic [NSLOT*IDX_W-1:0] ANS_OUT,
  output logic                   ANS_VALID,
  input  logic                   ANS_ACK,
  output logic [NSLOT*IDX_W-1:0] DISP_ANS,
  output logic [Q_W-1:0]         DISP_Q
);
  logic [NSLOT-1:0] sel_ev;
  logic clr_ev, dec_ev, flush, edit_ok, dec_fire;
  logic [NSLOT*IDX_W-1:0] slots, slot_nxt;
  logic [Q_W-1:0] q_reg;
  ae_state_t st;
  btn_edge #(.W(NSLOT + 2)) u_edge (
    .CLK(CLK),
    .RST(RST),
    .cur({DEC, CLR, SEL}),
    .ev ({dec_ev, clr_ev, sel_ev})
  );
  assign flush    = is_flush(4'(STATE));
  assign edit_ok  = st == EDIT && STATE == STATE_W'(ST_INPUT);
  assign dec_fire = edit_ok && dec_ev && !clr_ev && !(|sel_ev);
  for (genvar i = 0; i < NSLOT; i++) begin : g_slot
    logic [IDX_W-1:0] s, up, dn;
    assign s  = slots[i*IDX_W +: IDX_W];
    assign up = s >= IDX_W'(MAX_IDX) ? IDX_W'(1) : s + 1'b1;
    assign dn = s <= IDX_W'(1) ? IDX_W'(MAX_IDX) : s - 1'b1;
    assign slot_nxt[i*IDX_W +: IDX_W] = flush || (edit_ok && clr_ev) ? '0 :
                                        edit_ok && sel_ev[i] ? (DIR ? dn : up) : s;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      st        <= EDIT;
      slots     <= '0;
      ANS_OUT   <= '0;
      ANS_VALID <= 1'b0;
      q_reg     <= '0;
      QUE_OK    <= 1'b0;
      DISP_ANS  <= '0;
      DISP_Q    <= '0;
    end else begin
      slots    <= slot_nxt;
      DISP_ANS <= STATE == STATE_W'(ST_INPUT) ? slot_nxt : '0;
      DISP_Q   <= STATE == STATE_W'(ST_QUESTION) ? q_reg : '0;
      if (flush) begin
        st        <= FLUSH;
        ANS_OUT   <= '0;
        ANS_VALID <= 1'b0;
        q_reg     <= '0;
        QUE_OK    <= 1'b0;
      end else begin
        if (Q_LOAD) begin
          q_reg  <= Q_IN;
          QUE_OK <= 1'b1;
        end
        case (st)
          EDIT: if (dec_fire) begin
            ANS_OUT   <= slots;
            ANS_VALID <= 1'b1;
            st        <= PEND;
          end
          PEND: if (ANS_ACK && ANS_VALID) begin
            ANS_VALID <= 1'b0;
            st        <= EDIT;
          end
          default: st <= EDIT;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_answer_entry.sv
// tb_answer_entry: directed scoreboard bench for answer_entry
module tb_answer_entry;
  logic CLK = 0, RST = 1, DIR = 0, CLR = 0, DEC = 0, Q_LOAD = 0, ANS_ACK = 0;
  logic [3:0] STATE = 0;
  logic [2:0] SEL = 0;
  logic [11:0] Q_IN = 0;
  logic QUE_OK, ANS_VALID;
  logic [11:0] ANS_OUT, DISP_ANS, DISP_Q;
  int checks = 0, failures = 0;
  int m[3] = '{0, 0, 0};
  logic [31:0] sb[$];

  answer_entry dut (
    .CLK(CLK), .RST(RST), .STATE(STATE), .SEL(SEL), .DIR(DIR), .CLR(CLR), .DEC(DEC),
    .Q_LOAD(Q_LOAD), .Q_IN(Q_IN), .QUE_OK(QUE_OK), .ANS_OUT(ANS_OUT), .ANS_VALID(ANS_VALID),
    .ANS_ACK(ANS_ACK), .DISP_ANS(DISP_ANS), .DISP_Q(DISP_Q)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int stp(input int v, input logic d);
    if (d) return (v <= 1) ? 4 : v - 1;
    return (v >= 4) ? 1 : v + 1;
  endfunction

  function automatic logic [31:0] pack();
    return 32'(m[2] * 256 + m[1] * 16 + m[0]);
  endfunction

  task automatic chk_sb(input string tag, input logic [31:0] obs);
    if (sb.size() == 0) chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    else chk(tag, obs, sb.pop_front());
  endtask

  task automatic press(input logic [2:0] s, input logic d);
    SEL = s;
    DIR = d;
    for (int i = 0; i < 3; i++) if (s[i]) m[i] = stp(m[i], d);
    sb.push_back(pack());
    tick();
    chk_sb("press", DISP_ANS);
    SEL = 0;
    tick();
  endtask

  initial begin
    repeat (2) tick();
    chk("rst_que_ok", QUE_OK, 0);
    chk("rst_valid", ANS_VALID, 0);
    chk("rst_ans_out", ANS_OUT, 0);
    chk("rst_disp_ans", DISP_ANS, 0);
    chk("rst_disp_q", DISP_Q, 0);
    RST = 0;
    STATE = 4'b0100;
    tick();
    repeat (5) press(3'b001, 0);
    SEL = 3'b001;
    m[0] = stp(m[0], 0);
    sb.push_back(pack());
    tick();
    chk_sb("hold_first", DISP_ANS);
    repeat (9) tick();
    chk("hold_no_repeat", DISP_ANS, pack());
    SEL = 0;
    tick();
    press(3'b100, 1);
    press(3'b100, 1);
    press(3'b010, 0);
    SEL = 3'b010;
    CLR = 1;
    m = '{0, 0, 0};
    sb.push_back(pack());
    tick();
    chk_sb("clr_beats_sel", DISP_ANS);
    SEL = 0;
    CLR = 0;
    tick();
    press(3'b111, 0);
    press(3'b101, 0);
    press(3'b001, 0);
    DEC = 1;
    tick();
    chk("dec_valid", ANS_VALID, 1);
    chk("dec_ans_out", ANS_OUT, 12'h213);
    DEC = 0;
    tick();
    SEL = 3'b111;
    tick();
    SEL = 0;
    tick();
    chk("pend_frozen", DISP_ANS, pack());
    repeat (5) tick();
    chk("pend_valid_held", ANS_VALID, 1);
    chk("pend_ans_stable", ANS_OUT, 12'h213);
    ANS_ACK = 1;
    tick();
    chk("ack_valid_low", ANS_VALID, 0);
    ANS_ACK = 0;
    SEL = 3'b010;
    DEC = 1;
    m[1] = stp(m[1], 0);
    sb.push_back(pack());
    tick();
    chk_sb("dec_sel_step", DISP_ANS);
    chk("dec_sel_drop", ANS_VALID, 0);
    SEL = 0;
    DEC = 0;
    tick();
    Q_IN = 12'h105;
    Q_LOAD = 1;
    tick();
    chk("q_load_ok", QUE_OK, 1);
    Q_LOAD = 0;
    STATE = 4'b0011;
    tick();
    chk("disp_q_shown", DISP_Q, 12'h105);
    chk("disp_ans_hidden", DISP_ANS, 0);
    STATE = 4'b0100;
    tick();
    chk("disp_q_hidden", DISP_Q, 0);
    chk("disp_ans_back", DISP_ANS, pack());
    DEC = 1;
    tick();
    chk("dec2_valid", ANS_VALID, 1);
    chk("dec2_ans_out", ANS_OUT, 12'h223);
    DEC = 0;
    STATE = 4'b1010;
    Q_LOAD = 1;
    Q_IN = 12'h777;
    tick();
    chk("flush_valid", ANS_VALID, 0);
    chk("flush_que_ok", QUE_OK, 0);
    chk("flush_ans_out", ANS_OUT, 0);
    Q_LOAD = 0;
    STATE = 4'b0011;
    repeat (2) tick();
    chk("flush_q_ignored", DISP_Q, 0);
    m = '{0, 0, 0};
    STATE = 4'b0100;
    tick();
    chk("flush_slots", DISP_ANS, pack());
    press(3'b001, 0);
    DEC = 1;
    tick();
    chk("dec3_valid", ANS_VALID, 1);
    DEC = 0;
    tick();
    SEL = 3'b001;
    tick();
    RST = 1;
    tick();
    chk("rstp_valid", ANS_VALID, 0);
    chk("rstp_ans_out", ANS_OUT, 0);
    chk("rstp_disp_ans", DISP_ANS, 0);
    RST = 0;
    m = '{0, 0, 0};
    repeat (3) tick();
    chk("rstp_no_step", DISP_ANS, 0);
    SEL = 0;
    tick();
    press(3'b001, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/answer_entry.md
# answer_entry

Parametrised answer-entry and question-hold block for the factorisation game. It sits between the push-button/switch front end, the game controller's `STATE` bus and the answer checker. It keeps `NSLOT` prime-factor slots the player edits with edge-detected buttons, and latches the current question. It hands the committed answer to the checker over a valid/ack handshake and drives the display digits for the seven-segment decoders.

## Interface
Parameters:
- `NSLOT`, 3: number of factor slots.
- `IDX_W`, 4: width of one slot code.
- `MAX_IDX`, 4: largest slot code. Codes are 0=`-`, 1=2, 2=3, 3=5, 4=7.
- `Q_W`, 12: width of the latched question (3 BCD digits).
- `STATE_W`, 4: width of the controller state bus.

Ports. Clock and reset: one clock, `CLK`; reset `RST` is synchronous and active-high.
- `CLK` in 1: system clock.
- `RST` in 1: synchronous active-high reset.
- `STATE` in `STATE_W`: controller state.
- `SEL` in `NSLOT`: per-slot step buttons, level.
- `DIR` in 1: step direction, 0 = up, 1 = down.
- `CLR` in 1: clear-all button, level.
- `DEC` in 1: decide/commit button, level.
- `Q_LOAD` in 1: one-cycle strobe from the question database.
- `Q_IN` in `Q_W`: question digits, valid with `Q_LOAD`.
- `QUE_OK` out 1: question held.
- `ANS_OUT` out `NSLOT*IDX_W`: committed slot codes, slot 0 in the LSBs.
- `ANS_VALID` out 1: committed answer pending.
- `ANS_ACK` in 1: checker accepted the answer.
- `DISP_ANS` out `NSLOT*IDX_W`: live slot codes for display.
- `DISP_Q` out `Q_W`: question digits for display.

## Operation
- Shared package constants:
  - `ST_QUESTION = 4'b0011`, `ST_INPUT = 4'b0100`.
  - Flush states: `ST_DRAW = 4'b0110`, `ST_GOOD = 4'b1000`, `ST_OUCH = 4'b1001`, `ST_WIN = 4'b1010`, `ST_LOSE = 4'b1011`.
- Edge detection:
  - Every button is registered each cycle into a previous-value register.
  - An event is `cur & ~prev`; holding a button never auto-repeats.
- Internal FSM with three states: `EDIT`, `PEND`, `FLUSH`.
- `EDIT` is the reset state. Slots may change only when in `EDIT` and `STATE == ST_INPUT`.
- Priority within one cycle: `CLR` event > `SEL` events > `DEC` event.
- `CLR` event: all slots go to 0. Any `SEL`/`DEC` events in the same cycle are dropped.
- `SEL[i]` event:
  - Slot i steps.
  - Up: 0→1→…→`MAX_IDX`→1 (wraps to 1; code 0 is never re-entered by stepping).
  - Down: 1→`MAX_IDX`, 0→`MAX_IDX`, otherwise −1.
  - Several slots may step in the same cycle, each independently.
- `DEC` event with no `SEL`/`CLR` event:
  - `ANS_OUT` ← slots, `ANS_VALID` ← 1, FSM → `PEND`.
  - A `DEC` event in the same cycle as a `SEL` event is dropped.
- `PEND`:
  - Slots are frozen; `SEL`, `CLR` and `DEC` events are ignored.
  - `ANS_VALID` and `ANS_OUT` stay stable.
  - `ANS_ACK` while `ANS_VALID` is high → `ANS_VALID` ← 0, FSM → `EDIT`.
  - `ANS_ACK` while `ANS_VALID` is low is ignored.
- Flush. `STATE` in any flush state, from any FSM state:
  - Slots, `ANS_OUT`, the question register and `QUE_OK` all go to 0; `ANS_VALID` ← 0.
  - FSM → `FLUSH`, and stays there while the flush state persists.
  - Leaving the flush state → `EDIT`.
- Question load:
  - `Q_LOAD` in any state other than flush → question register ← `Q_IN`, `QUE_OK` ← 1.
  - `QUE_OK` stays 1 until the next flush or reset.
  - A second `Q_LOAD` overwrites the question.
  - `Q_LOAD` during flush is ignored; flush wins.
- Display outputs:
  - `DISP_ANS` = slots when `STATE == ST_INPUT`, else 0.
  - `DISP_Q` = question register when `STATE == ST_QUESTION`, else 0.
  - Both are registered.

## Timing
- Reset values:
  - Outputs: all 0, including `QUE_OK`, `ANS_VALID`, `ANS_OUT`, `DISP_ANS` and `DISP_Q`.
  - Slots 0; FSM `EDIT`.
  - Previous-value registers reset to all 1s, so buttons held through reset produce no event.
- Reset mid-`PEND` drops the pending answer; the checker sees `ANS_VALID` fall the cycle after `RST`.
- Latency:
  - Button rising at cycle n (first cycle sampled high) → slot updated at the edge ending cycle n.
  - `DISP_ANS` reflects the new slot value at n+1.
- `DEC` event at cycle n → `ANS_VALID` high from n+1.
- `ANS_ACK` sampled at cycle m → `ANS_VALID` low from m+1; the block can accept a new `DEC` event from m+1.
- `Q_LOAD` at n → `QUE_OK` and the question register valid from n+1; `DISP_Q` valid from n+2.
- Throughput: one commit per two cycles at best (`DEC`, then `ACK`).

## Structure
- Package `fact_pkg`:
  - The `STATE` encodings above.
  - The slot-code constants (`IDX_NONE = 0` … `IDX_7 = 4`).
  - Function `slot_to_prime` for the checker.
- Sub-module `btn_edge` (parameter `W`): register plus rising-edge detect; reset to all 1s.
- Slot update logic is a generate loop over `NSLOT`.

## Test plan
- Step up, `NSLOT=3`: `SEL[0]` pressed 5 times in `ST_INPUT` → slot 0 reads 1, 2, 3, 4, then wraps to 1. Holding `SEL[0]` for 10 cycles gives a single step.
- Step down and clear: `DIR=1`, `SEL[2]` from 0 → 4, then 3. `SEL[1]` and `CLR` in the same cycle → all slots 0.
- Commit handshake: slots {2,1,3} (slot 2 first), `DEC` → `ANS_OUT=12'h213` and `ANS_VALID` at +1. `SEL` presses while pending leave the slots unchanged. `ANS_ACK` held off 5 cycles, then asserted → `ANS_VALID` low at +1.
- Question path: `Q_LOAD` with `Q_IN=12'h105` → `QUE_OK=1` at +1; `STATE=ST_QUESTION` → `DISP_Q=12'h105`; `STATE=ST_INPUT` → `DISP_Q=0`.
- Flush: while `PEND`, `STATE=ST_WIN` → `ANS_VALID`, `QUE_OK` and slots all 0. `Q_LOAD` during `ST_WIN` is ignored.
- Reset: `RST` mid-`PEND` with `SEL[0]` held → all outputs 0; no step occurs after `RST` falls until `SEL[0]` is released and re-pressed.
